// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and sizing helpers for the systolic array sequencer.
//   state_t     - tile sequencer states (IDLE / LOAD / COMPUTE / DONE)
//   DIAGS       - anti-diagonal count for the default 5x5 array
//   diag_count  - anti-diagonal count for any array shape
//   cnt_width   - cycle counter width; wide enough for k_len_max+ROWS+COLS-2
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int ROWS_DEFAULT = 5;
  localparam int COLS_DEFAULT = 5;
  localparam int DIAGS        = ROWS_DEFAULT + COLS_DEFAULT - 1;

  function automatic int diag_count(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // KW+1 bits hold (2^KW-1)+ROWS+COLS-2 for any practical array size; the
  // clog2 term only matters for tiny KW with a large array.
  function automatic int cnt_width(input int kw, input int rows, input int cols);
    int a;
    int b;
    a = kw + 1;
    b = $clog2(rows + cols);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// skew_line: fixed-depth delay line for one fmap row.
//   clk    - clock
//   rst_n  - synchronous active-low clear
//   flush  - synchronous clear of every stage (tile abort)
//   din    - row input
//   dout   - din delayed by DEPTH cycles; DEPTH=0 is a plain wire
module skew_line #(
  parameter int BW    = 8,
  parameter int DEPTH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, flush};
      assign dout = din;
    end else begin : g_regs
      logic [BW-1:0] stage_reg [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: tile sequencer for a ROWS x COLS systolic array.
// One tile = ROWS cycles of weight preload, then a skewed MAC wavefront of
// k_len+ROWS+COLS-2 cycles, then a one-cycle done pulse.
//   clk, rst_n          - clock, synchronous active-low reset
//   start, abort, k_len - tile request, cancel, accumulation depth
//   i_fmap              - unskewed fmap vector (row r in slice r)
//   busy, done, err     - handshake toward the layer controller
//   w_rd_en, f_rd_en    - weight / fmap buffer read strobes
//   acc_clr             - accumulator clear on the first COMPUTE cycle
//   str_en, mul_en      - per-row weight store, per-anti-diagonal multiply
//   pe_en               - per-PE enable, bit r*COLS+c
//   o_fmap              - fmap with row r delayed r cycles
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int I_F_BW = 8,
  parameter int ROWS   = ROWS_DEFAULT,
  parameter int COLS   = COLS_DEFAULT,
  parameter int KW     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [KW-1:0]          k_len,
  input  logic [I_F_BW*ROWS-1:0] i_fmap,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   w_rd_en,
  output logic                   f_rd_en,
  output logic                   acc_clr,
  output logic [ROWS-1:0]        str_en,
  output logic [ROWS+COLS-2:0]   mul_en,
  output logic [ROWS*COLS-1:0]   pe_en,
  output logic [I_F_BW*ROWS-1:0] o_fmap
);

  localparam int NDIAG = diag_count(ROWS, COLS);
  localparam int CW    = cnt_width(KW, ROWS, COLS);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [KW-1:0]  k_len_reg, k_len_next;
  logic [CW-1:0]  last_t;
  logic           flush;

  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             w_rd_en_reg, w_rd_en_next;
  logic             f_rd_en_reg, f_rd_en_next;
  logic             acc_clr_reg, acc_clr_next;
  logic [ROWS-1:0]  str_en_reg, str_en_next;
  logic [NDIAG-1:0] mul_en_reg, mul_en_next;

  // Last COMPUTE index; k_len_reg is stable for the whole tile.
  assign last_t = CW'(k_len_reg) + CW'(ROWS + COLS - 3);
  assign flush  = abort && (state_reg != IDLE);

  // State register (control outputs registered alongside so they line up
  // with the state they belong to).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      k_len_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      w_rd_en_reg <= 1'b0;
      f_rd_en_reg <= 1'b0;
      acc_clr_reg <= 1'b0;
      str_en_reg  <= '0;
      mul_en_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      k_len_reg   <= k_len_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      w_rd_en_reg <= w_rd_en_next;
      f_rd_en_reg <= f_rd_en_next;
      acc_clr_reg <= acc_clr_next;
      str_en_reg  <= str_en_next;
      mul_en_reg  <= mul_en_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    k_len_next = k_len_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort && (k_len != '0)) begin
          state_next = LOAD;
          cnt_next   = '0;
          k_len_next = k_len;
        end
      end
      LOAD: begin
        if (cnt_reg == CW'(ROWS - 1)) begin
          state_next = COMPUTE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      COMPUTE: begin
        if (cnt_reg == last_t) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // Output decode from the upcoming state, so registered outputs coincide
  // with that state.
  always_comb begin
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == DONE);
    err_next     = (state_reg == IDLE) && start && !abort && (k_len == '0);
    w_rd_en_next = (state_next == LOAD);
    str_en_next  = {ROWS{state_next == LOAD}};
    f_rd_en_next = (state_next == COMPUTE) && (cnt_next < CW'(k_len_next));
    acc_clr_next = (state_next == COMPUTE) && (cnt_next == '0);
  end

  // Anti-diagonal d multiplies for k_len cycles starting at t=d.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NDIAG; gi++) begin : g_mul
      assign mul_en_next[gi] = (state_next == COMPUTE) &&
                               (cnt_next >= CW'(gi)) &&
                               (cnt_next < CW'(gi) + CW'(k_len_next));
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_pe_row
      for (gj = 0; gj < COLS; gj++) begin : g_pe_col
        assign pe_en[gi*COLS+gj] = str_en_reg[gi] | mul_en_reg[gi+gj];
      end
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_skew
      skew_line #(
        .BW    (I_F_BW),
        .DEPTH (gi)
      ) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .din   (i_fmap[gi*I_F_BW +: I_F_BW]),
        .dout  (o_fmap[gi*I_F_BW +: I_F_BW])
      );
    end
  endgenerate

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign w_rd_en = w_rd_en_reg;
  assign f_rd_en = f_rd_en_reg;
  assign acc_clr = acc_clr_reg;
  assign str_en  = str_en_reg;
  assign mul_en  = mul_en_reg;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed + randomized checks of systolic_ctrl against a
// tile-schedule model (position inside the tile -> expected outputs) and a
// per-cycle fmap history for the skew lines.
module tb_systolic_ctrl;

  localparam int BW   = 8;
  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int KW   = 8;
  localparam int ND   = ROWS + COLS - 1;
  localparam int HMAX = 8192;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 abort;
  logic [KW-1:0]        k_len;
  logic [BW*ROWS-1:0]   i_fmap;
  logic                 busy, done, err, w_rd_en, f_rd_en, acc_clr;
  logic [ROWS-1:0]      str_en;
  logic [ND-1:0]        mul_en;
  logic [ROWS*COLS-1:0] pe_en;
  logic [BW*ROWS-1:0]   o_fmap;

  systolic_ctrl #(.I_F_BW(BW), .ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .k_len   (k_len),
    .i_fmap  (i_fmap),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .w_rd_en (w_rd_en),
    .f_rd_en (f_rd_en),
    .acc_clr (acc_clr),
    .str_en  (str_en),
    .mul_en  (mul_en),
    .pe_en   (pe_en),
    .o_fmap  (o_fmap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: tile is active with position s (1-based cycle offset since the
  // accepting edge) and depth m_k.
  bit m_active = 1'b0;
  int m_s = 0;
  int m_k = 0;
  bit m_err = 1'b0;
  int last_clear = 0;
  logic [BW*ROWS-1:0] hist [HMAX];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_outputs(input logic [BW*ROWS-1:0] fm);
    int n_c, tot, t, src;
    bit ld, cp, dn;
    logic [ND-1:0] e_mul;
    logic [ROWS*COLS-1:0] e_pe;
    logic [BW*ROWS-1:0] e_fm;
    n_c = m_k + ROWS + COLS - 2;
    tot = ROWS + n_c + 1;
    ld = m_active && m_s >= 1 && m_s <= ROWS;
    cp = m_active && m_s > ROWS && m_s <= ROWS + n_c;
    dn = m_active && m_s == tot;
    t  = m_s - ROWS - 1;
    for (int d = 0; d < ND; d++) e_mul[d] = cp && t >= d && t < d + m_k;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        e_pe[r*COLS+c] = ld || (cp && t >= r + c && t < r + c + m_k);
    for (int r = 0; r < ROWS; r++) begin
      src = cyc - r;
      if (r == 0) e_fm[r*BW +: BW] = fm[r*BW +: BW];
      else if (src > last_clear) e_fm[r*BW +: BW] = hist[src][r*BW +: BW];
      else e_fm[r*BW +: BW] = '0;
    end
    check("busy",    64'(busy),    64'(m_active));
    check("done",    64'(done),    64'(dn));
    check("err",     64'(err),     64'(m_err));
    check("w_rd_en", 64'(w_rd_en), 64'(ld));
    check("str_en",  64'(str_en),  ld ? 64'h1F : 64'h0);
    check("f_rd_en", 64'(f_rd_en), 64'(cp && t < m_k));
    check("acc_clr", 64'(acc_clr), 64'(cp && t == 0));
    check("mul_en",  64'(mul_en),  64'(e_mul));
    check("pe_en",   64'(pe_en),   64'(e_pe));
    check("o_fmap",  64'(o_fmap),  64'(e_fm));
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, then clock
  // and advance the model.
  task automatic step(input bit rst, input bit st, input bit ab,
                      input logic [KW-1:0] k, input logic [BW*ROWS-1:0] fm);
    int tot;
    rst_n = rst; start = st; abort = ab; k_len = k; i_fmap = fm;
    #1;
    compare_outputs(fm);
    if (cyc < HMAX) hist[cyc] = fm;
    @(posedge clk);
    tot = ROWS + m_k + ROWS + COLS - 2 + 1;
    if (!rst) begin
      m_active = 1'b0; m_err = 1'b0; last_clear = cyc;
    end else if (m_active) begin
      m_err = 1'b0;
      if (ab) begin
        m_active = 1'b0; last_clear = cyc;
      end else if (m_s == tot) begin
        m_active = 1'b0;
      end else begin
        m_s++;
      end
    end else begin
      m_err = st && !ab && (k == '0);
      if (st && !ab && k != '0) begin
        m_active = 1'b1; m_s = 1; m_k = int'(k);
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic [BW*ROWS-1:0] pat(input int n);
    logic [BW*ROWS-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*BW +: BW] = 8'(8'h10 + r + n);
    return v;
  endfunction

  function automatic logic [BW*ROWS-1:0] rnd_fm();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[BW*ROWS-1:0];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 8'd0, pat(cyc));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; k_len = '0; i_fmap = '0;
    @(posedge clk);   // reset edge closes cycle 0
    last_clear = 0;
    cyc = 1;
    #1;

    // Reset state plus a couple of idle cycles.
    idle(2);

    // Basic tile, k_len=4.
    step(1, 1, 0, 8'd4, pat(cyc));
    idle(22);

    // Zero-length request is rejected.
    step(1, 1, 0, 8'd0, pat(cyc));
    idle(3);

    // start held throughout a tile: only one tile, one done.
    for (int i = 0; i < 24; i++) step(1, 1, 0, 8'd3, pat(cyc));
    idle(3);

    // Abort at COMPUTE t=3, then restart two cycles later.
    step(1, 1, 0, 8'd4, pat(cyc));
    idle(8);
    step(1, 0, 1, 8'd0, pat(cyc));
    idle(1);
    step(1, 1, 0, 8'd4, pat(cyc));
    idle(22);

    // abort and start together in IDLE: abort wins.
    step(1, 1, 1, 8'd4, pat(cyc));
    idle(2);

    // Maximum depth.
    step(1, 1, 0, 8'd255, rnd_fm());
    for (int i = 0; i < 275; i++) step(1, 0, 0, 8'd0, rnd_fm());

    // Reset mid-LOAD, then a k_len=1 tile.
    step(1, 1, 0, 8'd6, pat(cyc));
    idle(2);
    step(0, 0, 0, 8'd0, pat(cyc));
    step(1, 1, 0, 8'd1, pat(cyc));
    idle(18);

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      bit rs, st, ab;
      logic [KW-1:0] k;
      rs = ($urandom_range(0, 249) != 0);
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 59) == 0);
      k  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      step(rs, st, ab, k, rnd_fm());
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the ROWS x COLS ICG_APE systolic array.
- Runs one tile: weight preload, then a skewed multiply-accumulate wavefront, then a done pulse.
- Drives the array's str_en, mul_en and pe_en. Skews the per-row fmap stream so row r enters r cycles late.
- Sits between the tile buffers (fmap/weight read strobes) and the array; one start/busy/done handshake toward the layer controller.

Parameters:
- I_F_BW, 8, fmap element width.
- ROWS, 5, array rows.
- COLS, 5, array columns.
- KW, 8, width of the k_len configuration field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- start  in  1  request one tile; sampled in IDLE only.
- abort  in  1  cancel the tile in progress.
- k_len  in  KW  accumulation depth (fmap vectors per tile); latched on accepted start.
- i_fmap  in  I_F_BW*ROWS  unskewed fmap vector from the fmap buffer; row r in slice r.
- busy  out  1  tile in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when start is rejected.
- w_rd_en  out  1  weight buffer read strobe.
- f_rd_en  out  1  fmap buffer read strobe.
- acc_clr  out  1  one-cycle accumulator clear at COMPUTE entry.
- str_en  out  ROWS  to array.
- mul_en  out  ROWS+COLS-1  to array; bit d covers anti-diagonal r+c=d.
- pe_en  out  ROWS*COLS  to array; bit r*COLS+c.
- o_fmap  out  I_F_BW*ROWS  skewed fmap to array.

Behaviour:
- States: IDLE, LOAD, COMPUTE, DONE. Cycle counter cnt, width max(KW+1, clog2(ROWS+COLS)).
- Reset: state=IDLE; cnt=0; k_len_q=0. All outputs 0, including every skew-line register.
- IDLE:
  - start=1 and k_len!=0: latch k_len_q, go to LOAD next cycle.
  - start=1 and k_len==0: err=1 for one cycle, stay in IDLE.
  - start is ignored in every other state.
- LOAD: exactly ROWS cycles. In each: str_en all ones, w_rd_en=1, busy=1. Then go to COMPUTE with cnt=0.
- COMPUTE: exactly k_len_q+ROWS+COLS-2 cycles, t=cnt=0.. upward.
  - mul_en[d]=1 iff d <= t < d+k_len_q.
  - f_rd_en=1 iff t < k_len_q.
  - acc_clr=1 iff t==0.
  - str_en=0, busy=1.
  - After the last cycle, go to DONE.
- DONE: one cycle; done=1, busy=1. Then IDLE; busy=0 from the next cycle.
- Latency: start accepted at cycle T gives busy high T+1 .. T+ROWS+k_len+ROWS+COLS-1, and done in the last of those cycles.
- All control outputs are registered; they assert in the same cycle as the state they belong to.
- pe_en[r*COLS+c] = str_en[r] | mul_en[r+c]. It is decoded from the registered signals with no extra latency.
- Fmap skew: o_fmap slice r = i_fmap slice r delayed by r cycles; row 0 is combinational passthrough. Total ROWS*(ROWS-1)/2 registers.
- Skew registers advance every cycle. Their content is don't-care outside the mul_en window.
- Buffer read latency: fmap and weight data are valid in the cycle after their rd_en; the array expects this one-cycle alignment.
- abort=1 in LOAD, COMPUTE or DONE:
  - Next cycle state=IDLE; all enables, busy and acc_clr are 0; no done pulse.
  - Skew lines are flushed to 0.
- abort in IDLE has no effect. abort and start together in IDLE: abort wins, start is not accepted.
- rst_n low in any state: same as reset on that edge. rst_n has priority over abort and start.
- k_len_q = 2^KW-1 must complete without counter wrap. cnt must hold k_len_q+ROWS+COLS-2.

Decomposition:
- Package systolic_pkg holds the state enum (IDLE/LOAD/COMPUTE/DONE), the DIAGS=ROWS+COLS-1 constant and the cnt width function.
- Sub-module skew_line (params BW, DEPTH; DEPTH=0 means wire). Instantiated once per row with DEPTH=r; synchronous active-low clear plus a flush input.

Test Plan:
- k_len=4, ROWS=COLS=5, start at cycle 0:
  - str_en=5'h1F and w_rd_en at cycles 1-5.
  - acc_clr at cycle 6; f_rd_en at cycles 6-9.
  - mul_en[0] at cycles 6-9; mul_en[8] at cycles 14-17.
  - done at cycle 18; busy high 1-18, low at 19.
- Skew: drive i_fmap row r = 8'h10+r+cycle in COMPUTE. Expect o_fmap row 4 to equal the row-4 input from 4 cycles earlier. pe_en[24] is high only while mul_en[8] is high.
- start with k_len=0: err pulses for one cycle, busy stays 0. start held during busy: no second tile; done pulses once.
- abort at COMPUTE t=3 (k_len=4):
  - Next cycle: busy=0, mul_en=0, pe_en=0, o_fmap=0.
  - No done pulse.
  - A new start two cycles later runs a full tile with the correct timing.
- k_len=255: COMPUTE lasts 263 cycles, mul_en[8] high t=8..262, done exactly once.
- rst_n low for one cycle mid-LOAD: all outputs 0 on that edge. start with k_len=1 next: LOAD 5 cycles, COMPUTE 9 cycles, done.
